ip_backward_sched: RTL

IP_BACKWARD_SCHED -- requirements
Module: ip_backward_sched

---
 rtl/ip_sched_pkg.sv | 20 ++
 rtl/ip_sched_fifo.sv | 49 ++++
 rtl/ip_backward_sched.sv | 131 +++++++++++++
 3 files changed

// File: rtl/ip_sched_pkg.sv
// Shared types and defaults for the inner-product backward scheduler.
package ip_sched_pkg;

    localparam int DEF_LATENCY   = 33;
    localparam int DEF_OUT_DEPTH = 4;
    localparam int DEF_ID_W      = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } sched_state_t;

    // Result FIFO entry layout for the default tag width.
    typedef struct packed {
        logic [31:0]         data;
        logic [DEF_ID_W-1:0] id;
    } res_entry_t;

endpackage

// File: rtl/ip_sched_fifo.sv
// Synchronous result FIFO; head is presented combinationally from the read pointer.
module ip_sched_fifo
    import ip_sched_pkg::*;
#(
    parameter int DEPTH = DEF_OUT_DEPTH,
    parameter int WIDTH = $bits(res_entry_t)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
            if (pop)  rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/ip_backward_sched.sv
// Credit-based job scheduler around a fixed-latency inner-product datapath.
// Define IP_SCHED_PERF_EN to add the perf_issued / perf_stall counters.
module ip_backward_sched
    import ip_sched_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int LATENCY   = DEF_LATENCY,
    parameter int OUT_DEPTH = DEF_OUT_DEPTH,
    parameter int ID_W      = DEF_ID_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   job_valid,
    output logic                   job_ready,
    input  logic [WIDTH-1:0][31:0] job_in_data,
    input  logic [WIDTH-1:0][31:0] job_weights,
    input  logic [31:0]            job_bias,
    input  logic [ID_W-1:0]        job_id,
    input  logic                   flush,
    output logic [WIDTH-1:0][31:0] dp_in_data,
    output logic [WIDTH-1:0][31:0] dp_weights,
    output logic [31:0]            dp_bias,
    output logic [ID_W-1:0]        dp_in_id,
    input  logic [31:0]            dp_out_data,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [31:0]            res_data,
    output logic [ID_W-1:0]        res_id,
    output logic                   busy,
    output logic                   flush_done
`ifdef IP_SCHED_PERF_EN
    ,
    output logic [31:0]            perf_issued,
    output logic [31:0]            perf_stall
`endif
);

    localparam int CW = $clog2(OUT_DEPTH + 1);

    sched_state_t                 state;
    logic [CW-1:0]                credits;
    logic [LATENCY-1:0]           vld_pipe;
    logic [LATENCY-1:0][ID_W-1:0] id_pipe;
    logic                         accept, push, pop;
    logic                         fifo_full, fifo_empty;
    logic [CW-1:0]                fifo_count;
    logic [ID_W+31:0]             fifo_head;

    assign job_ready  = reset && (state != ST_DRAIN) && (credits != '0);
    assign accept     = job_valid && job_ready;
    assign push       = vld_pipe[LATENCY-1];
    assign pop        = !fifo_empty && res_ready;
    assign res_valid  = !fifo_empty;
    assign {res_data, res_id} = fifo_head;
    assign busy       = (|vld_pipe) || !fifo_empty;
    // High exactly once per drain: the FSM leaves DRAIN on the next edge.
    assign flush_done = (state == ST_DRAIN) && !busy;

    always_ff @(posedge clk) begin
        id_pipe <= {id_pipe[LATENCY-2:0], job_id};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            credits    <= CW'(OUT_DEPTH);
            vld_pipe   <= '0;
            dp_in_data <= '0;
            dp_weights <= '0;
            dp_bias    <= '0;
            dp_in_id   <= '0;
        end else begin
            vld_pipe <= {vld_pipe[LATENCY-2:0], accept};
            if (accept) begin
                dp_in_data <= job_in_data;
                dp_weights <= job_weights;
                dp_bias    <= job_bias;
                dp_in_id   <= job_id;
            end
            // A credit covers a job from issue until its result leaves the FIFO.
            case ({accept, pop})
                2'b10:   credits <= credits - CW'(1);
                2'b01:   credits <= credits + CW'(1);
                default: ;
            endcase
            case (state)
                ST_IDLE:  if (flush) state <= ST_DRAIN;
                          else if (job_valid) state <= ST_RUN;
                ST_RUN:   if (flush) state <= ST_DRAIN;
                          else if (!busy && !job_valid) state <= ST_IDLE;
                ST_DRAIN: if (!busy) state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    ip_sched_fifo #(
        .DEPTH (OUT_DEPTH),
        .WIDTH (ID_W + 32)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({dp_out_data, id_pipe[LATENCY-1]}),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            assert (!(push && fifo_full));
            assert (fifo_count <= CW'(OUT_DEPTH));
        end
    end

`ifdef IP_SCHED_PERF_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_issued <= '0;
            perf_stall  <= '0;
        end else begin
            if (accept && (perf_issued != '1)) perf_issued <= perf_issued + 32'd1;
            if (job_valid && !job_ready && (perf_stall != '1)) perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule
